// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants, state encoding and helpers for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  localparam int unsigned     DEF_BIN_W  = 27;
  localparam int unsigned     DEF_DIGITS = 8;
  localparam longint unsigned BCD_LIMIT  = 64'd99_999_999;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Largest value representable in the given number of BCD digits (10^digits - 1).
  function automatic longint unsigned max_bcd(input int unsigned digits);
    longint unsigned v;
    v = 64'd1;
    for (int unsigned i = 0; i < digits; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one iteration per clock, BIN_W clocks per conversion.
// Values that do not fit in DIGITS BCD digits saturate to all nines with ovf set.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = DEF_BIN_W,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int unsigned     BCD_W = 4 * DIGITS;
  localparam int unsigned     CNT_W = $clog2(BIN_W);
  localparam longint unsigned LIMIT = (DIGITS == DEF_DIGITS) ? BCD_LIMIT : max_bcd(DIGITS);

  state_t             state, state_n;
  logic [BIN_W-1:0]   sh, sh_n;
  logic [BCD_W-1:0]   scratch, scratch_n, adj, bcd_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               ovf_pend, ovf_pend_n;
  logic               busy_n, done_n, ovf_n;

  // Per-digit add-3 correction applied before every shift.
  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sh       <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      ovf      <= 1'b0;
    end else begin
      sh       <= sh_n;
      scratch  <= scratch_n;
      cnt      <= cnt_n;
      ovf_pend <= ovf_pend_n;
      busy     <= busy_n;
      done     <= done_n;
      bcd      <= bcd_n;
      ovf      <= ovf_n;
    end
  end

  always_comb begin
    state_n    = state;
    sh_n       = sh;
    scratch_n  = scratch;
    cnt_n      = cnt;
    ovf_pend_n = ovf_pend;
    busy_n     = busy;
    done_n     = 1'b0;
    bcd_n      = bcd;
    ovf_n      = ovf;
    case (state)
      IDLE: begin
        if (start) begin
          sh_n       = bin;
          scratch_n  = '0;
          cnt_n      = '0;
          ovf_pend_n = 64'(bin) > LIMIT;
          busy_n     = 1'b1;
          state_n    = SHIFT;
        end
      end
      SHIFT: begin
        scratch_n = {adj[BCD_W-2:0], sh[BIN_W-1]};
        sh_n      = {sh[BIN_W-2:0], 1'b0};
        // The final iteration's result is loaded straight into bcd.
        if (cnt == CNT_W'(BIN_W - 1)) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          bcd_n   = ovf_pend ? {DIGITS{4'h9}} : scratch_n;
          ovf_n   = ovf_pend;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized scoreboard bench for bin_to_bcd_seq: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever done is seen.
module tb_bin_to_bcd_seq;

  localparam int unsigned BIN_W  = 27;
  localparam int unsigned DIGITS = 8;

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [BIN_W-1:0]  bin = '0;
  logic              busy, done, ovf;
  logic [31:0]       bcd;

  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Decimal reference: digit-by-digit division, saturating above eight digits.
  function automatic logic [31:0] ref_bcd(input longint unsigned v);
    logic [31:0] r;
    r = '0;
    if (v > 64'd99_999_999) return 32'h9999_9999;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      check("done_width", longint'(prev_done), 0);
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bcd", longint'(bcd), longint'(e.bcd));
        check("ovf", longint'(ovf), longint'(e.ovf));
        check("latency", cyc, e.cyc);
      end
    end
    prev_done = done;
  end

  task automatic push_exp(input longint unsigned v);
    exp_t e;
    e.bcd = ref_bcd(v);
    e.ovf = (v > 64'd99_999_999);
    e.cyc = cyc + 1 + int'(BIN_W);
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic convert(input longint unsigned v);
    wait_idle();
    start = 1'b1;
    bin   = BIN_W'(v);
    push_exp(v);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_bcd",  longint'(bcd),  0);
    check("rst_ovf",  longint'(ovf),  0);
    reset = 1'b1;
    @(negedge clk);

    // Directed values, including the saturation boundary.
    convert(0);
    convert(12_345_678);
    convert(99_999_999);
    convert(100_000_000);
    convert(64'h7FF_FFFF);

    // start held with another value while busy must be ignored until the done cycle.
    wait_idle();
    start = 1'b1;
    bin   = BIN_W'(42);
    push_exp(42);
    @(negedge clk);
    bin = BIN_W'(5);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 1, 0);
    push_exp(5);
    @(negedge clk);
    start = 1'b0;

    // Abort mid-conversion; start during reset must be ignored.
    convert(777);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    bin   = BIN_W'(5);
    void'(sb.pop_back());
    @(negedge clk);
    check("abort_busy", longint'(busy), 0);
    check("abort_done", longint'(done), 0);
    check("abort_bcd",  longint'(bcd),  0);
    check("abort_ovf",  longint'(ovf),  0);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repeat (35) @(negedge clk);
    check("post_rst_busy", longint'(busy), 0);
    convert(777);

    // Random in-range values, issued back to back.
    for (int i = 0; i < 1000; i++) convert(longint'($urandom_range(99_999_999, 0)));

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
